// File: rtl/fpmul_arb.sv
// fpmul_arb: round-robin arbiter/sequencer sharing one fpmul instance among N
// requesters. A winner's operands are latched in IDLE, Start is pulsed in
// ISSUE, WAIT holds until Done, and RESP returns product + flags to the owner.
//
// Ports:
//   Clk, Rst              clock, synchronous active-high reset
//   Req[N]                per-requester request level (sampled in IDLE only)
//   A_in/B_in[32*N]       operands, requester i in bits [32i+31:32i]
//   Gnt[N]                one-hot grant pulse (ISSUE)
//   Rsp_Valid[N]          one-hot response pulse (RESP)
//   Rsp_P, Rsp_Flags      product and {UF,OF,NaNF,InfF,DNF,ZF}
//   Rsp_TO                response is a timeout abort
//   Busy                  high outside IDLE
//   Mul_Start/A/B/Rst     to fpmul
//   Mul_Done/P/flags      from fpmul
//
// Optional feature: define FPMUL_ARB_TIMEOUT_EN to abort a WAIT lasting
// TIMEOUT cycles without Done (quiet-NaN response, multiplier reset pulse).
module fpmul_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N-1:0]    Req,
  input  logic [32*N-1:0] A_in,
  input  logic [32*N-1:0] B_in,
  output logic [N-1:0]    Gnt,
  output logic [N-1:0]    Rsp_Valid,
  output logic [31:0]     Rsp_P,
  output logic [5:0]      Rsp_Flags,
  output logic            Rsp_TO,
  output logic            Busy,
  output logic            Mul_Start,
  output logic [31:0]     Mul_A,
  output logic [31:0]     Mul_B,
  output logic            Mul_Rst,
  input  logic            Mul_Done,
  input  logic [31:0]     Mul_P,
  input  logic            Mul_UF,
  input  logic            Mul_OF,
  input  logic            Mul_NaNF,
  input  logic            Mul_InfF,
  input  logic            Mul_DNF,
  input  logic            Mul_ZF
);

  localparam int          PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU = N;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpmul_arb: N must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [31:0]    opa_q, opa_d;
  logic [31:0]    opb_q, opb_d;
  logic [31:0]    p_q, p_d;
  logic [5:0]     flags_q, flags_d;

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;
`endif

  // Round-robin winner: search ptr+1, ptr+2, ..., ptr (mod N).
  logic          win_found;
  logic [PW-1:0] win_idx;
  int unsigned   cand;
  int unsigned   sel;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NU; i++) begin
      cand = (32'(ptr_q) + i) % NU;
      if (!win_found && Req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
    sel = 32'(win_idx);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    p_d       = p_q;
    flags_d   = flags_q;
    Gnt       = '0;
    Rsp_Valid = '0;
    Mul_Start = 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          opa_d   = A_in[32*sel +: 32];
          opb_d   = B_in[32*sel +: 32];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        Gnt[owner_q] = 1'b1;
        Mul_Start    = 1'b1;
`ifdef FPMUL_ARB_TIMEOUT_EN
        cnt_d        = '0;
        to_d         = 1'b0;
`endif
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // Done has priority over a timeout expiring in the same cycle.
        if (Mul_Done) begin
          p_d     = Mul_P;
          flags_d = {Mul_UF, Mul_OF, Mul_NaNF, Mul_InfF, Mul_DNF, Mul_ZF};
          state_d = S_RESP;
        end
`ifdef FPMUL_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          p_d     = 32'h7FC0_0000;
          flags_d = 6'b001000;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        Rsp_Valid[owner_q] = 1'b1;
        ptr_d              = owner_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(N - 1);
      owner_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      p_q     <= '0;
      flags_q <= '0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      p_q     <= p_d;
      flags_q <= flags_d;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Mul_A     = opa_q;
  assign Mul_B     = opb_q;
  assign Rsp_P     = p_q;
  assign Rsp_Flags = flags_q;

`ifdef FPMUL_ARB_TIMEOUT_EN
  assign Rsp_TO  = to_q & (state_q == S_RESP);
  assign Mul_Rst = Rst | (to_q & (state_q == S_RESP));
`else
  assign Rsp_TO  = 1'b0;
  assign Mul_Rst = Rst;
`endif

endmodule

// File: tb/tb_fpmul_arb.sv
// Testbench for fpmul_arb: a behavioural multiplier with bench-chosen latency,
// a round-robin reference (pointer + winner search), and a transaction-level
// timeline derived from the documented cycle timing.
module tb_fpmul_arb;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    Req;
  logic [32*N-1:0] A_in, B_in;
  logic [N-1:0]    Gnt, Rsp_Valid;
  logic [31:0]     Rsp_P;
  logic [5:0]      Rsp_Flags;
  logic            Rsp_TO, Busy, Mul_Start, Mul_Rst;
  logic [31:0]     Mul_A, Mul_B;
  logic            Mul_Done = 1'b0;
  logic [31:0]     Mul_P = '0;
  logic [5:0]      mflags = '0;

  always #5 Clk = ~Clk;

  fpmul_arb #(.N(N), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .A_in(A_in), .B_in(B_in),
    .Gnt(Gnt), .Rsp_Valid(Rsp_Valid), .Rsp_P(Rsp_P), .Rsp_Flags(Rsp_Flags),
    .Rsp_TO(Rsp_TO), .Busy(Busy), .Mul_Start(Mul_Start), .Mul_A(Mul_A),
    .Mul_B(Mul_B), .Mul_Rst(Mul_Rst), .Mul_Done(Mul_Done), .Mul_P(Mul_P),
    .Mul_UF(mflags[5]), .Mul_OF(mflags[4]), .Mul_NaNF(mflags[3]),
    .Mul_InfF(mflags[2]), .Mul_DNF(mflags[1]), .Mul_ZF(mflags[0])
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in multiplier: result is an arbitrary but reproducible function
  // of the operands, so routing and capture timing are what get tested.
  function automatic logic [31:0] ref_p(input logic [31:0] a, input logic [31:0] b);
    return (a * 32'd3) + ({b[15:0], b[31:16]} ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [5:0] ref_f(input logic [31:0] a, input logic [31:0] b);
    return a[5:0] ^ b[11:6];
  endfunction

  int unsigned mul_lat  = 0;
  bit          mul_hang = 1'b0;
  int unsigned mcnt     = 0;
  logic [31:0] ma = '0, mb = '0;

  // Done arrives mul_lat cycles after the first WAIT cycle; P and flags carry
  // random junk whenever Done is low.
  always @(posedge Clk) begin
    if (Rst) begin
      Mul_Done <= 1'b0;
      mcnt     <= 0;
    end else if (Mul_Start) begin
      ma <= Mul_A;
      mb <= Mul_B;
      if (!mul_hang && mul_lat == 0) begin
        Mul_Done <= 1'b1;
        Mul_P    <= ref_p(Mul_A, Mul_B);
        mflags   <= ref_f(Mul_A, Mul_B);
      end else begin
        Mul_Done <= 1'b0;
        mcnt     <= mul_hang ? 0 : mul_lat;
        Mul_P    <= $urandom;
        mflags   <= 6'($urandom);
      end
    end else if (mcnt == 1) begin
      Mul_Done <= 1'b1;
      Mul_P    <= ref_p(ma, mb);
      mflags   <= ref_f(ma, mb);
      mcnt     <= 0;
    end else begin
      if (mcnt != 0) mcnt <= mcnt - 1;
      Mul_Done <= 1'b0;
      Mul_P    <= $urandom;
      mflags   <= 6'($urandom);
    end
  end

  // Round-robin reference.
  int ptr_m = N - 1;

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int i = 1; i <= N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic scramble();
    Req = N'($urandom);
    for (int i = 0; i < N; i++) begin
      A_in[32*i +: 32] = $urandom;
      B_in[32*i +: 32] = $urandom;
    end
  endtask

  // Starts on the falling edge of an IDLE cycle (cycle 0) and returns on the
  // falling edge of the IDLE cycle following RESP.
  task automatic run_txn(input logic [N-1:0] mask, input int unsigned lat,
                         input bit hold, input bit hang,
                         input bit fix, input logic [31:0] fa, input logic [31:0] fb);
    int          w;
    logic [31:0] ea, eb;
    logic [N-1:0] oh;
    int unsigned nw;
    w = rr_pick(mask, ptr_m);
    for (int i = 0; i < N; i++) begin
      A_in[32*i +: 32] = $urandom;
      B_in[32*i +: 32] = $urandom;
    end
    if (fix) begin
      A_in[32*w +: 32] = fa;
      B_in[32*w +: 32] = fb;
    end
    ea       = A_in[32*w +: 32];
    eb       = B_in[32*w +: 32];
    oh       = '0;
    oh[w]    = 1'b1;
    Req      = mask;
    mul_lat  = lat;
    mul_hang = hang;

    @(negedge Clk);
    chk("gnt", Gnt, oh);
    chk("mul_start", Mul_Start, 1);
    chk("mul_a", Mul_A, ea);
    chk("mul_b", Mul_B, eb);
    chk("busy_issue", Busy, 1);
    chk("rsp_in_issue", Rsp_Valid, 0);
    if (!hold) scramble();

    nw = hang ? TMO : lat + 1;
    for (int unsigned k = 0; k < nw; k++) begin
      @(negedge Clk);
      chk("gnt_in_wait", Gnt, 0);
      chk("rsp_in_wait", Rsp_Valid, 0);
      chk("start_in_wait", Mul_Start, 0);
      chk("mul_a_hold", Mul_A, ea);
      chk("busy_wait", Busy, 1);
      if (!hold) scramble();
    end

    @(negedge Clk);
    chk("rsp_valid", Rsp_Valid, oh);
    chk("gnt_in_resp", Gnt, 0);
    chk("mul_b_hold", Mul_B, eb);
    if (hang) begin
      chk("rsp_p_to", Rsp_P, 32'h7FC0_0000);
      chk("rsp_flags_to", Rsp_Flags, 6'b001000);
      chk("rsp_to", Rsp_TO, 1);
      chk("mul_rst_to", Mul_Rst, 1);
    end else begin
      chk("rsp_p", Rsp_P, ref_p(ea, eb));
      chk("rsp_flags", Rsp_Flags, ref_f(ea, eb));
      chk("rsp_to", Rsp_TO, 0);
      chk("mul_rst", Mul_Rst, 0);
    end
    if (!hold) Req = '0;
    ptr_m = w;

    @(negedge Clk);
    chk("busy_idle", Busy, 0);
    chk("gnt_idle", Gnt, 0);
    chk("rsp_idle", Rsp_Valid, 0);
    chk("mul_rst_idle", Mul_Rst, 0);
  endtask

  initial begin
    Rst  = 1'b1;
    Req  = '0;
    A_in = '0;
    B_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_gnt", Gnt, 0);
    chk("rst_rsp", Rsp_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_start", Mul_Start, 0);
    chk("rst_mul_a", Mul_A, 0);
    chk("rst_rsp_p", Rsp_P, 0);
    chk("rst_flags", Rsp_Flags, 0);
    chk("rst_to", Rsp_TO, 0);
    chk("rst_mul_rst", Mul_Rst, 1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("mul_rst_low", Mul_Rst, 0);

    // All requesters held high from reset: grants 0,1,2,3,0.
    for (int t = 0; t < 5; t++) run_txn('1, 1 + t, 1'b1, 1'b0, 1'b0, '0, '0);

    // Single request with 2.0 x 3.0 operands on requester 2.
    run_txn(4'b0100, 3, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4040_0000);

    // Pointer: serve 1, then 0 and 3 together -> 3 then 0.
    run_txn(4'b0010, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    run_txn(4'b1001, 2, 1'b0, 1'b0, 1'b0, '0, '0);
    run_txn(4'b1001, 2, 1'b0, 1'b0, 1'b0, '0, '0);

    // Done on the last WAIT cycle before a timeout would fire.
    run_txn(4'b0001, TMO - 1, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic with idle gaps and Req noise during WAIT.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        Req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge Clk);
          chk("gap_busy", Busy, 0);
          chk("gap_gnt", Gnt, 0);
        end
      end
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), 1'b0, 1'b0, '0, '0);
    end

    // Reset during WAIT aborts the transaction.
    Req      = 4'b0100;
    mul_hang = 1'b1;
    @(negedge Clk);
    chk("gnt_pre_rst", Gnt, 4'b0001 << rr_pick(4'b0100, ptr_m));
    Req = '0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("abort_busy", Busy, 0);
    chk("abort_gnt", Gnt, 0);
    chk("abort_rsp", Rsp_Valid, 0);
    chk("abort_start", Mul_Start, 0);
    chk("abort_mul_a", Mul_A, 0);
    chk("abort_mul_b", Mul_B, 0);
    chk("abort_rsp_p", Rsp_P, 0);
    chk("abort_mul_rst", Mul_Rst, 1);
    Rst      = 1'b0;
    mul_hang = 1'b0;
    ptr_m    = N - 1;
    @(negedge Clk);
    chk("post_abort_rsp", Rsp_Valid, 0);
    chk("post_abort_busy", Busy, 0);
    run_txn(4'b1010, 1, 1'b0, 1'b0, 1'b0, '0, '0);

`ifdef FPMUL_ARB_TIMEOUT_EN
    // Multiplier never answers: RESP lands in cycle 2 + TMO.
    run_txn(4'b0001, 0, 1'b0, 1'b1, 1'b0, '0, '0);
    run_txn(4'b0110, 2, 1'b0, 1'b0, 1'b0, '0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpmul_arb.md
# fpmul_arb

Round-robin arbiter and sequencer sharing a single `fpmul` single-precision multiplier between N requesters. It captures one requester's operands and pulses the multiplier's `Start`. It then waits for `Done` and returns the product and status flags to the owning requester with a one-cycle valid pulse. It sits between the client engines and the one `fpmul` instance, driving that instance's `Start`, `A` and `B`.

## Interface

Parameters:
- `N`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort. Used only with `FPMUL_ARB_TIMEOUT_EN`.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Req` in N: per-requester request level.
- `A_in` in 32*N: requester i operand A in bits [32i+31:32i].
- `B_in` in 32*N: requester i operand B, same packing.
- `Gnt` out N: one-hot, one-cycle grant pulse.
- `Rsp_Valid` out N: one-hot, one-cycle response pulse.
- `Rsp_P` out 32: product; valid when any `Rsp_Valid` bit is high.
- `Rsp_Flags` out 6: {UF, OF, NaNF, InfF, DNF, ZF}.
- `Rsp_TO` out 1: response is a timeout abort.
- `Busy` out 1: high in every state except IDLE.
- `Mul_Start` out 1: to `fpmul` `Start`.
- `Mul_A` out 32: to `fpmul` `A`.
- `Mul_B` out 32: to `fpmul` `B`.
- `Mul_Rst` out 1: to `fpmul` `Rst`.
- `Mul_Done` in 1: from `fpmul` `Done`.
- `Mul_P` in 32: from `fpmul` `P`.
- `Mul_UF`, `Mul_OF`, `Mul_NaNF`, `Mul_InfF`, `Mul_DNF`, `Mul_ZF` in 1 each: `fpmul` status flags.

## Operation

FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any `Req` bit is high, select the winner by round-robin: search order `ptr+1`, `ptr+2`, ..., `ptr` (mod N).
  - Latch the winner's `A_in`/`B_in` into the operand registers and record `owner`. Go to ISSUE.
  - If no `Req` bit is high, stay in IDLE.
- **ISSUE**
  - `Gnt[owner]` = 1 and `Mul_Start` = 1 for exactly this cycle. Go to WAIT.
- **WAIT**
  - Sample `Mul_Done`. On the first cycle it is high, capture `Mul_P` and the six flags. Go to RESP.
- **RESP**
  - `Rsp_Valid[owner]` = 1 with the captured `Rsp_P` and `Rsp_Flags`.
  - Update `ptr` to `owner`. Go to IDLE.
- `Mul_A`/`Mul_B` are driven from the operand registers and held stable from ISSUE through RESP.
- `Req` is sampled only in IDLE:
  - Requests raised or dropped in other states have no effect.
  - A requester may withdraw before it is granted.
  - A requester that still holds `Req` after its `Rsp_Valid` is treated as a new request and competes normally.
- Requesters keep `A_in`/`B_in` stable while `Req` is high and not yet granted. Once the grant is seen, the operands may change.
- Multiplier contract: `Mul_Done` is low from the cycle after `Mul_Start` until the result is ready. It is sampled only in WAIT.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `ptr` = N-1, so requester 0 has first priority.
  - Operand registers and captured result = 0.
- `Mul_Rst` is high whenever `Rst` is high.
- `Rst` asserted in any state aborts the transaction: no `Rsp_Valid` is issued and no partial result is retained.

## Timing

- Let `Req` be high in IDLE at cycle 0:
  - `Gnt` and `Mul_Start` are high in cycle 1.
  - WAIT begins in cycle 2.
  - If `Mul_Done` is first high at cycle d, `Rsp_Valid` is high at cycle d+1.
- Arbitration overhead: 3 cycles per transaction (IDLE, ISSUE, RESP) plus the multiplier latency. The earliest next `Gnt` is 2 cycles after `Rsp_Valid`.
- Simultaneous requests: exactly one `Gnt` bit is asserted. There is no starvation: each requester waits at most N-1 transactions.
- `Busy` rises in cycle 1 (ISSUE) and falls in the cycle after RESP.

## Configuration

- `FPMUL_ARB_TIMEOUT_EN` defined:
  - A counter clears in ISSUE and increments each WAIT cycle in which `Mul_Done` is low.
  - After `TIMEOUT` WAIT cycles without `Done`, go to RESP with `Rsp_TO` = 1, `Rsp_P` = 32'h7FC00000, and `Rsp_Flags` = 6'b001000 (NaNF only).
  - `Mul_Rst` pulses for one cycle during that RESP.
  - If `Done` and the timeout occur in the same cycle, `Done` wins.
- `FPMUL_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT holds indefinitely.
  - `Rsp_TO` is tied to 0 and `Mul_Rst` = `Rst`.

## Test plan

- **Single request:** `Req[2]`, `A_in[2]` = 0x40000000 (2.0), `B_in[2]` = 0x40400000 (3.0), with `fpmul` attached.
  - `Gnt[2]` and `Mul_Start` are single-cycle pulses with `Mul_A`/`Mul_B` = those values.
  - `Rsp_Valid[2]` pulses with `Rsp_P` = 0x40C00000 and `Rsp_Flags` = 0.
- **All four requesters held high from reset:**
  - Grants occur in order 0, 1, 2, 3, 0.
  - Each `Rsp_Valid` goes to the matching requester.
  - `Gnt` is never multi-hot.
- **Round-robin pointer:** after serving requester 1, raise `Req[0]` and `Req[3]` together. Grant order is 3 then 0.
- **Request timing outside IDLE:**
  - `Req[1]` raised only during WAIT and dropped before RESP: never granted.
  - `Req[1]` raised during WAIT and held: granted on the first IDLE cycle.
- **Reset mid-transaction:** `Rst` asserted in WAIT for one cycle.
  - Next cycle: all outputs 0, `Busy` = 0, no `Rsp_Valid`.
  - Next grant goes to the lowest-index requester.
- **Timeout (`FPMUL_ARB_TIMEOUT_EN` defined, `TIMEOUT` = 8, multiplier model never asserts `Done`):**
  - `Rsp_Valid` pulses in cycle 10 relative to the `Req` IDLE cycle (cycle 0).
  - `Rsp_TO` = 1, `Rsp_P` = 0x7FC00000, `Mul_Rst` pulses for one cycle.
